control_sequencer: RTL and testbench

- Sequencer stage of the control unit, directly upstream/downstream of the per-opcode instruction decoders.
- Fetches the instruction word from the data bus into the instruction register and drives the current state to the decoders.
- Consumes the selected decoder's 33-bit control word, gates it onto the datapath, advances state from the word's next_state field and holds the status flags the decoders read.

---
 rtl/control_sequencer.sv | 114 +++++++++++
 tb/tb_control_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Control-unit sequencer: fetches instructions into I, walks the EX states the
// decoders request, gates their control word onto the datapath and holds status flags.
module control_sequencer #(
  parameter logic [32:0] FETCH_CW = 33'h0FC0_0160,
  parameter logic [32:0] INERT_CW = 33'h07C0_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [63:0]      databus,
  input  logic             mem_ready,
  input  logic             halt,
  input  logic [32:0]      cw_dec,
  input  logic [3:0]       status_in,
  output logic [31:0]      I,
  output logic [1:0]       state,
  output logic [4:0]       status,
  output logic [32:0]      cw,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EX1   = 2'b01,
    EX2   = 2'b10,
    EX3   = 2'b11
  } state_t;

  localparam int BIT_RF_W      = 9;
  localparam int BIT_RAM_EN    = 8;
  localparam int BIT_PC_EN     = 6;
  localparam int BIT_STATUS_LD = 2;

  state_t           state_q, state_d;
  logic [31:0]      i_q;
  logic [4:0]       status_q;
  logic [CNT_W-1:0] count_q;

  logic i_load;
  logic status_load;
  logic retire;
  logic ex_stall;

  // Upper half of the bus carries data for other consumers, never instructions.
  logic unused_bus_bits;
  assign unused_bus_bits = ^databus[63:32];

  assign I           = i_q;
  assign state       = state_q;
  assign status      = status_q;
  assign instr_count = count_q;

  assign ex_stall = cw_dec[BIT_RAM_EN] && !mem_ready;

  always_comb begin
    state_d     = state_q;
    i_load      = 1'b0;
    status_load = 1'b0;
    retire      = 1'b0;
    cw          = INERT_CW;
    halted      = 1'b0;
    // While in reset the datapath must see a side-effect-free word.
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          if (halt) begin
            halted = 1'b1;
          end else begin
            cw = FETCH_CW;
            if (mem_ready) begin
              i_load  = 1'b1;
              state_d = EX1;
            end else begin
              cw[5:4] = 2'b00;
            end
          end
        end
        default: begin
          cw = cw_dec;
          // A stalled RAM access must not commit anything that cannot be replayed.
          if (ex_stall) begin
            cw[BIT_RF_W]      = 1'b0;
            cw[BIT_PC_EN]     = 1'b0;
            cw[BIT_STATUS_LD] = 1'b0;
            cw[5:4]           = 2'b00;
          end else begin
            state_d     = state_t'(cw_dec[1:0]);
            status_load = cw_dec[BIT_STATUS_LD];
            retire      = (cw_dec[1:0] == 2'b00);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      i_q      <= '0;
      status_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (i_load)
        i_q <= databus[31:0];
      if (status_load)
        status_q <= {1'b1, status_in};
      if (retire)
        count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; a second instance with a 4-bit counter
// shares all stimulus to exercise counter wrap.
module tb_control_sequencer;

  localparam logic [32:0] FETCH_CW_TB  = 33'h0FC0_0160;
  localparam logic [32:0] FETCH_WAIT   = 33'h0FC0_0140;
  localparam logic [32:0] INERT_CW_TB  = 33'h07C0_0000;

  logic        clock;
  logic        reset_n;
  logic [63:0] databus;
  logic        mem_ready;
  logic        halt;
  logic [32:0] cw_dec;
  logic [3:0]  status_in;

  logic [31:0] dut_i;
  logic [1:0]  dut_state;
  logic [4:0]  dut_status;
  logic [32:0] dut_cw;
  logic [31:0] dut_count;
  logic        dut_halted;

  logic [31:0] sm_i;
  logic [1:0]  sm_state;
  logic [4:0]  sm_status;
  logic [32:0] sm_cw;
  logic [3:0]  sm_count;
  logic        sm_halted;

  int n_cmp;
  int n_bad;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .databus(databus), .mem_ready(mem_ready),
    .halt(halt), .cw_dec(cw_dec), .status_in(status_in),
    .I(dut_i), .state(dut_state), .status(dut_status), .cw(dut_cw),
    .instr_count(dut_count), .halted(dut_halted)
  );

  control_sequencer #(.CNT_W(4)) dut_small (
    .clock(clock), .reset_n(reset_n), .databus(databus), .mem_ready(mem_ready),
    .halt(halt), .cw_dec(cw_dec), .status_in(status_in),
    .I(sm_i), .state(sm_state), .status(sm_status), .cw(sm_cw),
    .instr_count(sm_count), .halted(sm_halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cw_dec = 33'h1_FFFF_FFFF;
    halt = 1'b0;
    mem_ready = 1'b1;
    databus = 64'hFFFF_FFFF_AAAA_AAAA;
    #2 reset_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (dut_cw !== INERT_CW_TB) begin n_bad++; $display("[TB] FAIL reset_cw: got %h expected %h", dut_cw, INERT_CW_TB); end
    n_cmp++; if (dut_state !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_state: got %b expected 00", dut_state); end
    n_cmp++; if (dut_count !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d expected 0", dut_count); end
    n_cmp++; if (dut_i !== 32'd0 || dut_status !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_regs: got I=%h status=%b expected 0/0", dut_i, dut_status); end
    n_cmp++; if (dut_halted !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_halted: got %b expected 0", dut_halted); end
    reset_n = 1'b1;
    databus = 64'h5555_5555_9400_0010;
    #1;
    n_cmp++; if (dut_cw !== FETCH_CW_TB) begin n_bad++; $display("[TB] FAIL fetch_cw: got %h expected %h", dut_cw, FETCH_CW_TB); end
    step();
    n_cmp++; if (dut_i !== 32'h9400_0010) begin n_bad++; $display("[TB] FAIL fetch_I: got %h expected 94000010", dut_i); end
    n_cmp++; if (dut_state !== 2'b01) begin n_bad++; $display("[TB] FAIL fetch_state: got %b expected 01", dut_state); end
  endtask

  task automatic test_single_step();
    cw_dec = 33'h1_2345_6600;
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (dut_cw !== 33'h1_2345_6600) begin n_bad++; $display("[TB] FAIL ex_pass_cw: got %h expected 123456600", dut_cw); end
    step();
    n_cmp++; if (dut_state !== 2'b00 || dut_count !== 32'd1) begin n_bad++; $display("[TB] FAIL ex_retire: got state=%b count=%0d expected 00/1", dut_state, dut_count); end
    n_cmp++; if (dut_status !== 5'd0) begin n_bad++; $display("[TB] FAIL ex_no_status: got %b expected 00000", dut_status); end
  endtask

  task automatic test_fetch_wait();
    databus = 64'h0000_0000_DEAD_BEEF;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (dut_cw !== FETCH_WAIT) begin n_bad++; $display("[TB] FAIL wait_cw[%0d]: got %h expected %h", k, dut_cw, FETCH_WAIT); end
      step();
      n_cmp++; if (dut_i !== 32'h9400_0010 || dut_state !== 2'b00) begin n_bad++; $display("[TB] FAIL wait_hold[%0d]: got I=%h state=%b expected 94000010/00", k, dut_i, dut_state); end
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (dut_cw[5:4] !== FETCH_CW_TB[5:4]) begin n_bad++; $display("[TB] FAIL wait_done_pcfs: got %b expected %b", dut_cw[5:4], FETCH_CW_TB[5:4]); end
    step();
    n_cmp++; if (dut_i !== 32'hDEAD_BEEF || dut_state !== 2'b01) begin n_bad++; $display("[TB] FAIL wait_done_load: got I=%h state=%b expected deadbeef/01", dut_i, dut_state); end
  endtask

  task automatic test_ex_stall();
    cw_dec = 33'h1_0000_03F4;
    status_in = 4'b1111;
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (dut_cw !== 33'h1_0000_0180) begin n_bad++; $display("[TB] FAIL stall_cw[%0d]: got %h expected 100000180", k, dut_cw); end
      step();
      n_cmp++; if (dut_state !== 2'b01 || dut_count !== 32'd1 || dut_status !== 5'd0) begin n_bad++; $display("[TB] FAIL stall_hold[%0d]: got state=%b count=%0d status=%b expected 01/1/00000", k, dut_state, dut_count, dut_status); end
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (dut_cw !== 33'h1_0000_03F4) begin n_bad++; $display("[TB] FAIL unstall_cw: got %h expected 1000003f4", dut_cw); end
    step();
    n_cmp++; if (dut_state !== 2'b00 || dut_count !== 32'd2) begin n_bad++; $display("[TB] FAIL unstall_retire: got state=%b count=%0d expected 00/2", dut_state, dut_count); end
    n_cmp++; if (dut_status !== 5'b1_1111) begin n_bad++; $display("[TB] FAIL unstall_status: got %b expected 11111", dut_status); end
  endtask

  task automatic test_multi_step();
    databus = 64'h0000_0000_1234_5678;
    mem_ready = 1'b1;
    step();
    cw_dec = 33'h0_0000_0006;
    status_in = 4'b0101;
    mem_ready = 1'b0;
    step();
    n_cmp++; if (dut_state !== 2'b10 || dut_status !== 5'b1_0101) begin n_bad++; $display("[TB] FAIL multi_ex1: got state=%b status=%b expected 10/10101", dut_state, dut_status); end
    n_cmp++; if (dut_count !== 32'd2) begin n_bad++; $display("[TB] FAIL multi_ex1_count: got %0d expected 2", dut_count); end
    cw_dec = 33'h0_0000_0000;
    status_in = 4'b1010;
    step();
    n_cmp++; if (dut_state !== 2'b00 || dut_count !== 32'd3) begin n_bad++; $display("[TB] FAIL multi_ex2: got state=%b count=%0d expected 00/3", dut_state, dut_count); end
    n_cmp++; if (dut_status !== 5'b1_0101 || dut_i !== 32'h1234_5678) begin n_bad++; $display("[TB] FAIL multi_hold: got status=%b I=%h expected 10101/12345678", dut_status, dut_i); end
  endtask

  task automatic test_loop();
    mem_ready = 1'b1;
    step();
    cw_dec = 33'h0_0000_0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (dut_cw !== 33'h0_0000_0001) begin n_bad++; $display("[TB] FAIL loop_cw[%0d]: got %h expected 000000001", k, dut_cw); end
      step();
      n_cmp++; if (dut_state !== 2'b01 || dut_count !== 32'd3) begin n_bad++; $display("[TB] FAIL loop_hold[%0d]: got state=%b count=%0d expected 01/3", k, dut_state, dut_count); end
    end
    cw_dec = 33'h0_0000_0003;
    step();
    n_cmp++; if (dut_state !== 2'b11) begin n_bad++; $display("[TB] FAIL loop_ex3: got %b expected 11", dut_state); end
    cw_dec = 33'h0_0000_0000;
    step();
    n_cmp++; if (dut_state !== 2'b00 || dut_count !== 32'd4) begin n_bad++; $display("[TB] FAIL loop_retire: got state=%b count=%0d expected 00/4", dut_state, dut_count); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    mem_ready = 1'b1;
    databus = 64'h0000_0000_CAFE_0001;
    #1;
    n_cmp++; if (dut_halted !== 1'b1 || dut_cw !== INERT_CW_TB) begin n_bad++; $display("[TB] FAIL halt_fetch: got halted=%b cw=%h expected 1/%h", dut_halted, dut_cw, INERT_CW_TB); end
    n_cmp++; if (dut_cw[6:3] !== 4'b0000) begin n_bad++; $display("[TB] FAIL halt_pc_fields: got %b expected 0000", dut_cw[6:3]); end
    step();
    n_cmp++; if (dut_state !== 2'b00 || dut_i !== 32'h1234_5678) begin n_bad++; $display("[TB] FAIL halt_hold: got state=%b I=%h expected 00/12345678", dut_state, dut_i); end
    halt = 1'b0;
    step();
    halt = 1'b1;
    cw_dec = 33'h0_0000_0000;
    #1;
    n_cmp++; if (dut_halted !== 1'b0 || dut_state !== 2'b01) begin n_bad++; $display("[TB] FAIL halt_in_ex: got halted=%b state=%b expected 0/01", dut_halted, dut_state); end
    step();
    n_cmp++; if (dut_count !== 32'd5 || dut_halted !== 1'b1) begin n_bad++; $display("[TB] FAIL halt_after_ex: got count=%0d halted=%b expected 5/1", dut_count, dut_halted); end
    halt = 1'b0;
    #1;
    n_cmp++; if (dut_cw !== FETCH_CW_TB || dut_halted !== 1'b0) begin n_bad++; $display("[TB] FAIL halt_resume_cw: got cw=%h halted=%b expected %h/0", dut_cw, dut_halted, FETCH_CW_TB); end
    step();
    n_cmp++; if (dut_state !== 2'b01 || dut_i !== 32'hCAFE_0001) begin n_bad++; $display("[TB] FAIL halt_resume: got state=%b I=%h expected 01/cafe0001", dut_state, dut_i); end
    step();
  endtask

  task automatic test_wrap();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mem_ready = 1'b1;
    cw_dec = 33'h0_0000_0000;
    for (int k = 0; k < 16; k++) begin
      step();
      step();
    end
    n_cmp++; if (sm_count !== 4'd0) begin n_bad++; $display("[TB] FAIL wrap_small: got %0d expected 0", sm_count); end
    n_cmp++; if (dut_count !== 32'd16) begin n_bad++; $display("[TB] FAIL wrap_wide: got %0d expected 16", dut_count); end
  endtask

  task automatic test_reset_mid_op();
    databus = 64'h0000_0000_0BAD_F00D;
    mem_ready = 1'b1;
    step();
    cw_dec = 33'h0_0000_0006;
    status_in = 4'b0011;
    step();
    n_cmp++; if (dut_state !== 2'b10 || dut_status !== 5'b1_0011) begin n_bad++; $display("[TB] FAIL mid_setup: got state=%b status=%b expected 10/10011", dut_state, dut_status); end
    cw_dec = 33'h0_0000_0000;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (dut_state !== 2'b00 || dut_status !== 5'd0 || dut_i !== 32'd0) begin n_bad++; $display("[TB] FAIL mid_async: got state=%b status=%b I=%h expected 00/00000/0", dut_state, dut_status, dut_i); end
    n_cmp++; if (dut_cw !== INERT_CW_TB || dut_count !== 32'd0) begin n_bad++; $display("[TB] FAIL mid_cw_count: got cw=%h count=%0d expected %h/0", dut_cw, dut_count, INERT_CW_TB); end
    step();
    reset_n = 1'b1;
    mem_ready = 1'b0;
    step();
    n_cmp++; if (dut_count !== 32'd0 || dut_state !== 2'b00) begin n_bad++; $display("[TB] FAIL mid_release: got count=%0d state=%b expected 0/00", dut_count, dut_state); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b1;
    databus = '0;
    mem_ready = 1'b0;
    halt = 1'b0;
    cw_dec = '0;
    status_in = '0;
    test_reset();
    test_single_step();
    test_fetch_wait();
    test_ex_stall();
    test_multi_step();
    test_loop();
    test_halt();
    test_wrap();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
